bp_me_wormhole_packet_serializer: RTL and testbench
===================================================

BP_ME_WORMHOLE_PACKET_SERIALIZER -- requirements
Module: bp_me_wormhole_packet_serializer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- flit_width_p, "inv", link flit width in bits.
- cord_width_p, "inv", router coordinate width.
- cid_width_p, "inv", concentrator id width.
- len_width_p, "inv", flit-count field width.
- hdr_width_p, "inv", mem message header width.
- data_width_p, "inv", maximum payload width in bits (block width).
- resp_mode_p, 0, selects the message set: 0 = command encoder, 1 = response encoder.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_i, in, 1, clock.
- reset_i, in, 1, synchronous active-high reset.
- hdr_i, in, hdr_width_p, bp mem header: msg_type, size, addr, payload.
- data_i, in, data_width_p, message data.
- src_cord_i, in, cord_width_p, source coordinate.
- src_cid_i, in, cid_width_p, source concentrator id.
- dst_cord_i, in, cord_width_p, destination coordinate.
- dst_cid_i, in, cid_width_p, destination concentrator id.
- v_i, in, 1, message valid.
- ready_o, out, 1, message accept.
- link_data_o, out, flit_width_p, outgoing flit.
- link_v_o, out, 1, flit valid.
- link_ready_i, in, 1, downstream ready.
- drop_o, out, 1, one-cycle pulse when an unsupported msg_type is discarded.
REQ-003 The block SHALL use one clock, clk_i; reset_i SHALL be synchronous and active-high.

Function
REQ-004 Packet layout, LSB first: {data, hdr, src_cid, src_cord, len, cid, cord}, cord at bit 0. The packet SHALL be zero-padded to P = CDIV(H + data_width_p, flit_width_p) flits, where H = 2*cord_width_p + 2*cid_width_p + len_width_p + hdr_width_p.
REQ-005 Data-carrying types SHALL be:
- Response mode: e_cce_mem_rd, e_cce_mem_uc_rd.
- Command mode: e_cce_mem_wr, e_cce_mem_uc_wr.
REQ-006 Ack-only types SHALL be:
- Response mode: e_cce_mem_wr, e_cce_mem_uc_wr, e_cce_mem_pre.
- Command mode: e_cce_mem_rd, e_cce_mem_uc_rd, e_cce_mem_pre.
REQ-007 All other msg_type values are unsupported.
REQ-008 Payload bits D:
- Data-carrying: D = min(8*2^size, data_width_p), with e_mem_size_1..e_mem_size_64 mapping to 1..64 bytes.
- Ack-only: D = 0.
- len = CDIV(H + D, flit_width_p) - 1, computed at elaboration-constant width and truncated to len_width_p.
REQ-009 Parameter check: P-1 SHALL fit in len_width_p; otherwise an elaboration-time error SHALL be raised.
REQ-010 FSM states:
- e_ready: ready_o = 1, link_v_o = 0.
- e_send: ready_o = 0, link_v_o = 1.
REQ-011 In e_ready, on v_i & ready_o:
- Supported type: capture the packet and len into registers, clear the flit counter, go to e_send next cycle.
- Unsupported type: pulse drop_o that cycle and stay in e_ready.
REQ-012 In e_send, link_data_o SHALL equal packet[cnt*flit_width_p +: flit_width_p].
REQ-013 The counter SHALL advance only on link_v_o & link_ready_i.
REQ-014 When a handshake occurs with cnt == len, the FSM SHALL return to e_ready next cycle. Flits beyond len SHALL never be emitted.
REQ-015 Input-to-first-flit latency SHALL be 1 cycle. There SHALL be one bubble cycle between packets because ready_o is low in e_send.
REQ-016 link_data_o and link_v_o SHALL hold stable while link_v_o & ~link_ready_i; no flit is skipped or repeated.
REQ-017 The registered packet SHALL be unaffected by input changes during e_send.
REQ-018 A single-flit packet (len = 0) SHALL complete on its first handshake.

Reset
REQ-019 When reset_i is high at a clock edge:
- FSM goes to e_ready and the counter to 0.
- link_v_o = 0 and drop_o = 0.
- ready_o = 0 while reset_i is asserted.
REQ-020 A reset mid-packet SHALL abandon the remaining flits; no partial resumption after reset.

Verification
Parameters for all scenarios: flit 64, cord 7, cid 2, len 4, hdr 49, data 512 (H = 71).
REQ-021 Response mode, e_cce_mem_rd, size 64, link_ready_i held 1 -> len = 9; 10 flits on consecutive cycles starting 1 cycle after accept; flit0[6:0] = dst_cord_i; ready_o returns high the cycle after flit 9.
REQ-022 Response mode, e_cce_mem_wr -> len = 1; exactly 2 flits; flit1 carries hdr bits and zero padding above bit 70.
REQ-023 Response mode, e_cce_mem_uc_rd, size 8 -> len = 2; 3 flits; flit1[63:7] and flit2[6:0] hold data[63:0].
REQ-024 Size-64 read with link_ready_i toggling 1,0,0,1,... -> data stable during stalls; total of 10 distinct in-order flits.
REQ-025 Unsupported msg_type with v_i = 1 -> drop_o = 1 for one cycle, link_v_o stays 0, ready_o stays 1.
REQ-026 reset_i asserted after flit 3 of a 10-flit packet -> link_v_o = 0 next cycle; a following ack message yields exactly 2 fresh flits.

Source files
------------

// File: rtl/bp_me_wormhole_packet_serializer.sv
// Serializes a bp mem header plus payload into a burst of wormhole link flits.
// Header fields used here: msg_type = hdr_i[3:0], size = hdr_i[6:4].
module bp_me_wormhole_packet_serializer #(
    parameter int unsigned flit_width_p = 64,
    parameter int unsigned cord_width_p = 7,
    parameter int unsigned cid_width_p  = 2,
    parameter int unsigned len_width_p  = 4,
    parameter int unsigned hdr_width_p  = 49,
    parameter int unsigned data_width_p = 512,
    parameter int unsigned resp_mode_p  = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [hdr_width_p-1:0]  hdr_i,
    input  logic [data_width_p-1:0] data_i,
    input  logic [cord_width_p-1:0] src_cord_i,
    input  logic [cid_width_p-1:0]  src_cid_i,
    input  logic [cord_width_p-1:0] dst_cord_i,
    input  logic [cid_width_p-1:0]  dst_cid_i,
    input  logic                    v_i,
    output logic                    ready_o,
    output logic [flit_width_p-1:0] link_data_o,
    output logic                    link_v_o,
    input  logic                    link_ready_i,
    output logic                    drop_o
);

    localparam int unsigned HdrBits  = 2 * cord_width_p + 2 * cid_width_p + len_width_p
                                       + hdr_width_p;
    localparam int unsigned NumFlits = (HdrBits + data_width_p + flit_width_p - 1)
                                       / flit_width_p;
    localparam int unsigned CntW     = (NumFlits > 1) ? $clog2(NumFlits) : 1;

    localparam logic [3:0] e_cce_mem_rd    = 4'd0;
    localparam logic [3:0] e_cce_mem_wr    = 4'd1;
    localparam logic [3:0] e_cce_mem_uc_rd = 4'd2;
    localparam logic [3:0] e_cce_mem_uc_wr = 4'd3;
    localparam logic [3:0] e_cce_mem_pre   = 4'd4;

    localparam logic [0:0] e_ready = 1'b0;
    localparam logic [0:0] e_send  = 1'b1;

    function automatic int unsigned payload_bits(input int unsigned size);
        int unsigned b;
        b = 8 << size;
        return (b > data_width_p) ? data_width_p : b;
    endfunction

    function automatic logic [len_width_p-1:0] len_for(input int unsigned d);
        int unsigned n;
        n = (HdrBits + d + flit_width_p - 1) / flit_width_p - 1;
        return n[len_width_p-1:0];
    endfunction

    function automatic logic [data_width_p-1:0] mask_for(input int unsigned d);
        logic [data_width_p-1:0] m;
        for (int unsigned i = 0; i < data_width_p; i++) m[i] = (i < d);
        return m;
    endfunction

    if ((NumFlits - 1) >= (1 << len_width_p)) begin : g_len_check
        $error("packet flit count does not fit in len_width_p");
    end

    localparam logic [len_width_p-1:0] AckLen = len_for(0);

    // Per-size length and payload mask tables, all elaboration constants.
    logic [7:0][len_width_p-1:0]  data_len;
    logic [7:0][data_width_p-1:0] data_mask;
    for (genvar s = 0; s < 8; s++) begin : g_size_tbl
        assign data_len[s]  = len_for(payload_bits(s));
        assign data_mask[s] = mask_for(payload_bits(s));
    end

    logic [0:0]                                state_q, state_d;
    logic [len_width_p-1:0]                    cnt_q, cnt_d;
    logic [len_width_p-1:0]                    len_q, len_d;
    logic [NumFlits-1:0][flit_width_p-1:0]     pkt_q, pkt_d;
    logic [NumFlits*flit_width_p-1:0]          pkt_flat;

    logic [3:0]              msg_type;
    logic [2:0]              msg_size;
    logic                    rd_like, wr_like, is_pre, is_data, is_ack, accept;
    logic [len_width_p-1:0]  msg_len;
    logic [data_width_p-1:0] payload;

    always_comb begin
        msg_type = hdr_i[3:0];
        msg_size = hdr_i[6:4];
        rd_like  = (msg_type == e_cce_mem_rd) | (msg_type == e_cce_mem_uc_rd);
        wr_like  = (msg_type == e_cce_mem_wr) | (msg_type == e_cce_mem_uc_wr);
        is_pre   = (msg_type == e_cce_mem_pre);
        is_data  = (resp_mode_p != 0) ? rd_like : wr_like;
        is_ack   = ((resp_mode_p != 0) ? wr_like : rd_like) | is_pre;
        msg_len  = is_data ? data_len[msg_size] : AckLen;
        payload  = is_data ? (data_i & data_mask[msg_size]) : '0;

        ready_o     = (state_q == e_ready) & ~reset_i;
        link_v_o    = (state_q == e_send) & ~reset_i;
        link_data_o = pkt_q[cnt_q[CntW-1:0]];
        accept      = v_i & ready_o & (is_data | is_ack);
        drop_o      = v_i & ready_o & ~(is_data | is_ack);

        pkt_flat = '0;
        pkt_flat[HdrBits+data_width_p-1:0] = {payload, hdr_i, src_cid_i, src_cord_i, msg_len,
                                              dst_cid_i, dst_cord_i};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        pkt_d   = pkt_q;
        if (state_q == e_ready) begin
            if (accept) begin
                pkt_d   = pkt_flat;
                len_d   = msg_len;
                cnt_d   = '0;
                state_d = e_send;
            end
        end else if (link_ready_i) begin
            if (cnt_q == len_q) state_d = e_ready;
            else                cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_ready;
            cnt_q   <= '0;
            len_q   <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            pkt_q   <= pkt_d;
        end
    end

endmodule

// File: tb/tb_bp_me_wormhole_packet_serializer.sv
// Self-checking bench: vector table, hand sequences and randomized messages
// against a flit-queue reference model of the packet layout.
module tb_bp_me_wormhole_packet_serializer;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [48:0]  hdr_i;
    logic [511:0] data_i;
    logic [6:0]   src_cord_i, dst_cord_i;
    logic [1:0]   src_cid_i, dst_cid_i;
    logic         v_i, ready_o, link_v_o, link_ready_i, drop_o;
    logic [63:0]  link_data_o;

    always #5 clk_i = ~clk_i;

    bp_me_wormhole_packet_serializer #(
        .flit_width_p(64), .cord_width_p(7), .cid_width_p(2), .len_width_p(4),
        .hdr_width_p(49), .data_width_p(512), .resp_mode_p(1)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .hdr_i(hdr_i), .data_i(data_i),
        .src_cord_i(src_cord_i), .src_cid_i(src_cid_i), .dst_cord_i(dst_cord_i),
        .dst_cid_i(dst_cid_i), .v_i(v_i), .ready_o(ready_o), .link_data_o(link_data_o),
        .link_v_o(link_v_o), .link_ready_i(link_ready_i), .drop_o(drop_o)
    );

    int passed = 0;
    int total  = 0;

    logic [48:0]  cur_hdr;
    logic [511:0] cur_data;
    logic [6:0]   cur_src_cord, cur_dst_cord;
    logic [1:0]   cur_src_cid, cur_dst_cid;
    logic [63:0]  exp_q[$];
    logic [63:0]  act_q[$];
    logic         last_drop;

    typedef struct {
        logic [3:0] mt;
        logic [2:0] sz;
        int         mode;
        int         nflits;
        logic       drop;
    } vec_t;
    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h required %h", name, act, exp);
        else passed++;
    endtask

    task automatic scramble();
        hdr_i      = 49'({$urandom(), $urandom()});
        for (int i = 0; i < 16; i++) data_i[i*32 +: 32] = $urandom();
        src_cord_i = 7'($urandom());
        dst_cord_i = 7'($urandom());
        src_cid_i  = 2'($urandom());
        dst_cid_i  = 2'($urandom());
    endtask

    // Reference: response-mode message set, fields packed LSB first.
    task automatic build_model();
        logic [3:0]   mt;
        int           sz, d, nfl;
        logic [3:0]   len;
        logic [511:0] md;
        logic [639:0] pkt;
        mt = cur_hdr[3:0];
        sz = int'(cur_hdr[6:4]);
        exp_q.delete();
        if (mt > 4) return;
        d = 0;
        if (mt == 0 || mt == 2) begin
            d = 8 * (1 << sz);
            if (d > 512) d = 512;
        end
        nfl = (71 + d + 63) / 64;
        len = 4'(nfl - 1);
        md  = '0;
        for (int i = 0; i < d; i++) md[i] = cur_data[i];
        pkt = 640'(cur_dst_cord) | (640'(cur_dst_cid) << 7) | (640'(len) << 9)
            | (640'(cur_src_cord) << 13) | (640'(cur_src_cid) << 20)
            | (640'(cur_hdr) << 22) | (640'(md) << 71);
        for (int f = 0; f < nfl; f++) exp_q.push_back(pkt[f*64 +: 64]);
    endtask

    task automatic drive_msg(input logic [3:0] mt, input logic [2:0] sz);
        cur_hdr = 49'({$urandom(), $urandom()});
        cur_hdr[3:0] = mt;
        cur_hdr[6:4] = sz;
        for (int i = 0; i < 16; i++) cur_data[i*32 +: 32] = $urandom();
        cur_src_cord = 7'($urandom());
        cur_dst_cord = 7'($urandom());
        cur_src_cid  = 2'($urandom());
        cur_dst_cid  = 2'($urandom());
        build_model();
        act_q.delete();
        hdr_i = cur_hdr; data_i = cur_data;
        src_cord_i = cur_src_cord; dst_cord_i = cur_dst_cord;
        src_cid_i = cur_src_cid; dst_cid_i = cur_dst_cid;
        v_i = 1'b1;
        link_ready_i = 1'b1;
        #1;
        chk("accept_ready", 64'(ready_o), 64'd1);
        chk("accept_drop", 64'(drop_o), 64'(exp_q.size() == 0));
        last_drop = drop_o;
        @(posedge clk_i); #1;
        v_i = 1'b0;
        scramble();
    endtask

    // mode 0: always ready, 1: 1,0,0 repeating, 2: random backpressure.
    task automatic run_msg(input logic [3:0] mt, input logic [2:0] sz, input int mode);
        int          idx, cyc;
        logic        held_v;
        logic [63:0] held;
        drive_msg(mt, sz);
        idx = 0; cyc = 0; held_v = 1'b0; held = '0;
        while (idx < exp_q.size() && cyc < 300) begin
            if (mode == 0)      link_ready_i = 1'b1;
            else if (mode == 1) link_ready_i = (cyc % 3 == 0);
            else                link_ready_i = ($urandom_range(0, 2) != 0);
            #1;
            chk("send_v", 64'(link_v_o), 64'd1);
            chk("send_ready", 64'(ready_o), 64'd0);
            if (held_v) chk("stall_hold", link_data_o, held);
            if (link_ready_i) begin
                act_q.push_back(link_data_o);
                chk($sformatf("flit%0d", idx), link_data_o, exp_q[idx]);
                idx++;
                held_v = 1'b0;
            end else begin
                held   = link_data_o;
                held_v = 1'b1;
            end
            @(posedge clk_i); #1;
            scramble();
            cyc++;
        end
        chk("no_timeout", 64'(cyc < 300), 64'd1);
        link_ready_i = 1'b1;
        #1;
        chk("end_v", 64'(link_v_o), 64'd0);
        chk("end_ready", 64'(ready_o), 64'd1);
        chk("end_drop", 64'(drop_o), 64'd0);
    endtask

    initial begin
        logic [63:0] fl;
        vecs[0]  = '{4'd0, 3'd6, 0, 10, 1'b0};
        vecs[1]  = '{4'd1, 3'd6, 0, 2,  1'b0};
        vecs[2]  = '{4'd2, 3'd3, 0, 3,  1'b0};
        vecs[3]  = '{4'd3, 3'd0, 2, 2,  1'b0};
        vecs[4]  = '{4'd4, 3'd2, 0, 2,  1'b0};
        vecs[5]  = '{4'd0, 3'd0, 0, 2,  1'b0};
        vecs[6]  = '{4'd0, 3'd7, 2, 10, 1'b0};
        vecs[7]  = '{4'd2, 3'd4, 0, 4,  1'b0};
        vecs[8]  = '{4'd0, 3'd5, 1, 6,  1'b0};
        vecs[9]  = '{4'd2, 3'd2, 0, 2,  1'b0};
        vecs[10] = '{4'd2, 3'd1, 2, 2,  1'b0};
        vecs[11] = '{4'd5, 3'd6, 0, 0,  1'b1};
        vecs[12] = '{4'd9, 3'd3, 0, 0,  1'b1};
        vecs[13] = '{4'd15, 3'd0, 0, 0, 1'b1};

        reset_i = 1'b1; v_i = 1'b1; link_ready_i = 1'b0;
        scramble();
        hdr_i[3:0] = 4'd7;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_link_v", 64'(link_v_o), 64'd0);
        chk("rst_drop", 64'(drop_o), 64'd0);
        reset_i = 1'b0; v_i = 1'b0;
        #1;
        chk("post_rst_ready", 64'(ready_o), 64'd1);
        chk("post_rst_link_v", 64'(link_v_o), 64'd0);
        @(posedge clk_i); #1;

        foreach (vecs[i]) begin
            run_msg(vecs[i].mt, vecs[i].sz, vecs[i].mode);
            chk($sformatf("tbl%0d_nflits", i), 64'(act_q.size()), 64'(vecs[i].nflits));
            chk($sformatf("tbl%0d_drop", i), 64'(last_drop), 64'(vecs[i].drop));
        end

        // Full-block read: flit 0 leads with destination coordinate.
        run_msg(4'd0, 3'd6, 0);
        fl = act_q[0];
        chk("rd64_dst_cord", 64'(fl[6:0]), 64'(cur_dst_cord));
        // Ack: second flit holds top header bits then zero padding.
        run_msg(4'd1, 3'd6, 0);
        fl = act_q[1];
        chk("ack_hdr_tail", 64'(fl[6:0]), 64'(cur_hdr[48:42]));
        chk("ack_zero_pad", 64'(fl[63:7]), 64'd0);
        // 8-byte uncached read straddles flits 1 and 2.
        run_msg(4'd2, 3'd3, 0);
        fl = act_q[1];
        chk("uc8_flit1", 64'(fl[63:7]), 64'(cur_data[56:0]));
        fl = act_q[2];
        chk("uc8_flit2", 64'(fl[6:0]), 64'(cur_data[63:57]));
        run_msg(4'd0, 3'd6, 1);
        chk("stall_nflits", 64'(act_q.size()), 64'd10);

        // Reset after three flits of a ten-flit packet.
        drive_msg(4'd0, 3'd6);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("pre_rst_flit", link_data_o, exp_q[k]);
            @(posedge clk_i); #1;
        end
        reset_i = 1'b1;
        #1;
        chk("mid_rst_v", 64'(link_v_o), 64'd0);
        @(posedge clk_i); #1;
        chk("mid_rst_v2", 64'(link_v_o), 64'd0);
        chk("mid_rst_ready", 64'(ready_o), 64'd0);
        reset_i = 1'b0;
        #1;
        chk("after_rst_v", 64'(link_v_o), 64'd0);
        chk("after_rst_ready", 64'(ready_o), 64'd1);
        @(posedge clk_i); #1;
        run_msg(4'd1, 3'd0, 0);
        chk("after_rst_ack_nflits", 64'(act_q.size()), 64'd2);

        for (int r = 0; r < 40; r++) begin
            run_msg(4'($urandom_range(0, 7)), 3'($urandom()), 2);
            chk("rand_nflits", 64'(act_q.size()), 64'(exp_q.size()));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
